// File: rtl/fas_freq_analyzer.sv
// fas_freq_analyzer
//   Analysis stage behind the 16-point FFT. Captures one complex frame, scans
//   it one bin per cycle computing |X[k]|^2 = re^2 + im^2, and reports the
//   index of the largest bin on freq with a one-cycle done pulse.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   fft_valid  one-cycle strobe: fft_frame holds a complete frame
//   fft_frame  bin k at [2*DW*k +: 2*DW]; real = upper DW bits, imag = lower
//   busy       high while a captured frame is being scanned
//   done       one-cycle pulse: freq updated
//   freq       index of the largest-magnitude bin of the last completed frame
//   overrun    sticky: a frame arrived while busy and was dropped
module fas_freq_analyzer #(
  parameter int N_BINS  = 16,
  parameter int DW      = 16,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fft_valid,
  input  logic [N_BINS*2*DW-1:0]      fft_frame,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_BINS)-1:0]   freq,
  output logic                        overrun
);

  localparam int IW = $clog2(N_BINS);
  localparam int FW = N_BINS * 2 * DW;
  localparam int MW = 2 * DW + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_BINS - 1);
  localparam logic [IW-1:0] BEST_INIT = SKIP_DC ? IW'(1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [MW-1:0]   max_q, max_d;
  logic [IW-1:0]   best_q, best_d;
  logic [IW-1:0]   freq_q, freq_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  // Magnitude of the bin currently addressed by idx_q
  logic [2*DW-1:0]        bin_word;
  logic signed [2*DW-1:0] re_ext, im_ext;
  logic [2*DW-1:0]        re_sq, im_sq;
  logic [MW-1:0]          mag;
  logic                   take;
  logic [IW-1:0]          best_next;

  always_comb begin
    bin_word = frame_q[2*DW*idx_q +: 2*DW];
    re_ext   = {{DW{bin_word[2*DW-1]}}, bin_word[2*DW-1:DW]};
    im_ext   = {{DW{bin_word[DW-1]}},   bin_word[DW-1:0]};
    // Squares of DW-bit signed values are non-negative and fit in 2*DW bits
    re_sq    = re_ext * re_ext;
    im_sq    = im_ext * im_ext;
    mag      = {1'b0, re_sq} + {1'b0, im_sq};
    take     = (mag > max_q) && !(SKIP_DC && (idx_q == '0));
    best_next = take ? idx_q : best_q;
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    max_d     = max_q;
    best_d    = best_q;
    freq_d    = freq_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (fft_valid) begin
          frame_d = fft_frame;
          idx_d   = '0;
          max_d   = '0;
          best_d  = BEST_INIT;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (fft_valid) begin
          overrun_d = 1'b1;
        end
        if (take) begin
          max_d = mag;
        end
        best_d = best_next;
        if (idx_q == LAST_IDX) begin
          freq_d  = best_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      best_q    <= '0;
      freq_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      best_q    <= best_d;
      freq_q    <= freq_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign freq    = freq_q;
  assign overrun = overrun_q;

endmodule
